// File: rtl/reg_writeback_pkg.sv
// Shared constants and grant encoding for the register-file write-back front end.
package reg_writeback_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam logic [WB_ADDR_W-1:0] WB_REG_ZERO = '0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } gnt_e;

endpackage

// File: rtl/reg_writeback_rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs load) with a last-grant register.
module wb_rr_arb2
    import reg_writeback_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_alu,
    input  logic i_req_ld,
    output logic o_gnt_alu,
    output logic o_gnt_ld
);

    gnt_e r_last;
    logic w_conflict;

    assign w_conflict = i_req_alu & i_req_ld;

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        o_gnt_alu = i_req_alu;
        o_gnt_ld  = i_req_ld;
        if (w_conflict) begin
            o_gnt_alu = (r_last == GNT_LD);
            o_gnt_ld  = (r_last == GNT_ALU);
        end
    end

    // History moves only on a real conflict, so a lone requester never steals the next turn.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= GNT_LD;
        end else if (w_conflict) begin
            r_last <= o_gnt_alu ? GNT_ALU : GNT_LD;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and load results onto the register file's single write port and
// tracks which registers still await a write for decode hazard stalls.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                WB_clk,
    input  logic                WB_rst,
    input  logic                WB_alloc_valid,
    input  logic [ADDR_W-1:0]   WB_alloc_addr,
    input  logic                WB_alu_valid,
    output logic                WB_alu_ready,
    input  logic [ADDR_W-1:0]   WB_alu_addr,
    input  logic [DATA_W-1:0]   WB_alu_data,
    input  logic                WB_ld_valid,
    output logic                WB_ld_ready,
    input  logic [ADDR_W-1:0]   WB_ld_addr,
    input  logic [DATA_W-1:0]   WB_ld_data,
    output logic                WB_reg_write,
    output logic [ADDR_W-1:0]   WB_reg_addr,
    output logic [DATA_W-1:0]   WB_reg_data,
    output logic [(2**ADDR_W)-1:0] WB_pending
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic                w_gnt_alu;
    logic                w_gnt_ld;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_pending_nxt;

    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [DATA_W-1:0]   r_reg_data;
    logic [NUM_REGS-1:0] r_pending;

    wb_rr_arb2 u_arb (
        .i_clk     (WB_clk),
        .i_rst     (WB_rst),
        .i_req_alu (WB_alu_valid),
        .i_req_ld  (WB_ld_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_ld  (w_gnt_ld)
    );

    assign WB_alu_ready = w_gnt_alu;
    assign WB_ld_ready  = w_gnt_ld;
    assign w_xfer       = w_gnt_alu | w_gnt_ld;
    assign w_sel_addr   = w_gnt_ld ? WB_ld_addr : WB_alu_addr;
    assign w_sel_data   = w_gnt_ld ? WB_ld_data : WB_alu_data;

    // Writes to register 0 complete the handshake but never assert the write enable.
    always_ff @(posedge WB_clk) begin
        if (WB_rst) begin
            r_reg_write <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
        end else if (w_xfer) begin
            r_reg_write <= (w_sel_addr != WB_REG_ZERO);
            r_reg_addr  <= w_sel_addr;
            r_reg_data  <= w_sel_data;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Clear coincides with the register-file commit; a same-edge alloc overrides it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_reg_write) begin
            w_pending_nxt[r_reg_addr] = 1'b0;
        end
        if (WB_alloc_valid && (WB_alloc_addr != WB_REG_ZERO)) begin
            w_pending_nxt[WB_alloc_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge WB_clk) begin
        if (WB_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign WB_reg_write = r_reg_write;
    assign WB_reg_addr  = r_reg_addr;
    assign WB_reg_data  = r_reg_data;
    assign WB_pending   = r_pending;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

    logic        WB_clk = 1'b0;
    logic        WB_rst;
    logic        WB_alloc_valid;
    logic [4:0]  WB_alloc_addr;
    logic        WB_alu_valid;
    logic        WB_alu_ready;
    logic [4:0]  WB_alu_addr;
    logic [31:0] WB_alu_data;
    logic        WB_ld_valid;
    logic        WB_ld_ready;
    logic [4:0]  WB_ld_addr;
    logic [31:0] WB_ld_data;
    logic        WB_reg_write;
    logic [4:0]  WB_reg_addr;
    logic [31:0] WB_reg_data;
    logic [31:0] WB_pending;

    int total = 0;
    int bad   = 0;

    always #5 WB_clk = ~WB_clk;

    reg_writeback dut (
        .WB_clk         (WB_clk),
        .WB_rst         (WB_rst),
        .WB_alloc_valid (WB_alloc_valid),
        .WB_alloc_addr  (WB_alloc_addr),
        .WB_alu_valid   (WB_alu_valid),
        .WB_alu_ready   (WB_alu_ready),
        .WB_alu_addr    (WB_alu_addr),
        .WB_alu_data    (WB_alu_data),
        .WB_ld_valid    (WB_ld_valid),
        .WB_ld_ready    (WB_ld_ready),
        .WB_ld_addr     (WB_ld_addr),
        .WB_ld_data     (WB_ld_data),
        .WB_reg_write   (WB_reg_write),
        .WB_reg_addr    (WB_reg_addr),
        .WB_reg_data    (WB_reg_data),
        .WB_pending     (WB_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge WB_clk);
        #1;
    endtask

    task automatic idle_inputs();
        WB_alloc_valid = 1'b0;
        WB_alloc_addr  = '0;
        WB_alu_valid   = 1'b0;
        WB_alu_addr    = '0;
        WB_alu_data    = '0;
        WB_ld_valid    = 1'b0;
        WB_ld_addr     = '0;
        WB_ld_data     = '0;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] a,
                             input logic [31:0] d);
        check({tag, ".we"}, 32'(WB_reg_write), 32'(we));
        check({tag, ".addr"}, 32'(WB_reg_addr), 32'(a));
        check({tag, ".data"}, WB_reg_data, d);
    endtask

    initial begin
        idle_inputs();
        // Reset held two cycles with both sources and an alloc active.
        WB_rst = 1'b1;
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd6;
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd1; WB_alu_data = 32'hAAAA_0001;
        WB_ld_valid  = 1'b1; WB_ld_addr  = 5'd2; WB_ld_data  = 32'hBBBB_0002;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("rst", 1'b0, 5'd0, 32'h0);
            check("rst.pend", WB_pending, 32'h0);
        end
        WB_rst = 1'b0;
        idle_inputs();
        step();
        check("post_rst.we", 32'(WB_reg_write), 32'h0);
        check("post_rst.pend", WB_pending, 32'h0);

        // Conflict: ALU wins first, then load, then lone ALU, then hold.
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd3; WB_alu_data = 32'h11;
        WB_ld_valid  = 1'b1; WB_ld_addr  = 5'd4; WB_ld_data  = 32'h22;
        #1;
        check("cf1.alu_rdy", 32'(WB_alu_ready), 32'h1);
        check("cf1.ld_rdy", 32'(WB_ld_ready), 32'h0);
        step();
        check_out("cf1", 1'b1, 5'd3, 32'h11);
        check("cf2.alu_rdy", 32'(WB_alu_ready), 32'h0);
        check("cf2.ld_rdy", 32'(WB_ld_ready), 32'h1);
        step();
        check_out("cf2", 1'b1, 5'd4, 32'h22);
        WB_ld_valid = 1'b0;
        #1;
        check("solo.alu_rdy", 32'(WB_alu_ready), 32'h1);
        step();
        check_out("solo", 1'b1, 5'd3, 32'h11);
        idle_inputs();
        step();
        check_out("hold", 1'b0, 5'd3, 32'h11);

        // Single ALU write with scoreboard set and clear timing.
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd5;
        step();
        WB_alloc_valid = 1'b0;
        check("a5.pend", WB_pending, 32'h0000_0020);
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd5; WB_alu_data = 32'hDEAD_BEEF;
        #1;
        check("a5.alu_rdy", 32'(WB_alu_ready), 32'h1);
        step();
        WB_alu_valid = 1'b0;
        check_out("a5", 1'b1, 5'd5, 32'hDEAD_BEEF);
        check("a5.pend_still", WB_pending, 32'h0000_0020);
        step();
        check("a5.pend_clr", WB_pending, 32'h0);
        check("a5.we_off", 32'(WB_reg_write), 32'h0);

        // Register 0: handshake completes, no write, no pending bit.
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd0;
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd0; WB_alu_data = 32'hFFFF_FFFF;
        #1;
        check("r0.alu_rdy", 32'(WB_alu_ready), 32'h1);
        step();
        idle_inputs();
        check("r0.we", 32'(WB_reg_write), 32'h0);
        check("r0.pend", WB_pending, 32'h0);

        // Set/clear collision on register 7: set wins.
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd7;
        step();
        WB_alloc_valid = 1'b0;
        check("c7.pend", WB_pending, 32'h0000_0080);
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd7; WB_alu_data = 32'h77;
        step();
        WB_alu_valid = 1'b0;
        check_out("c7", 1'b1, 5'd7, 32'h77);
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd7;
        step();
        WB_alloc_valid = 1'b0;
        check("c7.set_wins", WB_pending, 32'h0000_0080);
        WB_alu_valid = 1'b1; WB_alu_data = 32'h78;
        step();
        WB_alu_valid = 1'b0;
        step();
        check("c7.final_clr", WB_pending, 32'h0);

        // Back-to-back load stream 8, 9, 10 with no bubbles.
        for (int i = 8; i <= 10; i++) begin
            WB_alloc_valid = 1'b1; WB_alloc_addr = 5'(i);
            step();
        end
        WB_alloc_valid = 1'b0;
        check("ld.pend", WB_pending, 32'h0000_0700);
        WB_ld_valid = 1'b1; WB_ld_addr = 5'd8; WB_ld_data = 32'h80;
        #1;
        check("ld8.rdy", 32'(WB_ld_ready), 32'h1);
        step();
        check_out("ld8", 1'b1, 5'd8, 32'h80);
        WB_ld_addr = 5'd9; WB_ld_data = 32'h90;
        step();
        check_out("ld9", 1'b1, 5'd9, 32'h90);
        check("ld9.pend", WB_pending, 32'h0000_0600);
        WB_ld_addr = 5'd10; WB_ld_data = 32'hA0;
        step();
        WB_ld_valid = 1'b0;
        check_out("ld10", 1'b1, 5'd10, 32'hA0);
        check("ld10.pend", WB_pending, 32'h0000_0400);
        step();
        check("ld.done.we", 32'(WB_reg_write), 32'h0);
        check("ld.done.pend", WB_pending, 32'h0);

        // Reset mid-operation discards the in-flight write and pending bits.
        WB_alloc_valid = 1'b1; WB_alloc_addr = 5'd12;
        step();
        WB_alloc_valid = 1'b0;
        WB_alu_valid = 1'b1; WB_alu_addr = 5'd12; WB_alu_data = 32'hC0DE;
        step();
        WB_alu_valid = 1'b0;
        check_out("mid", 1'b1, 5'd12, 32'hC0DE);
        WB_rst = 1'b1;
        step();
        WB_rst = 1'b0;
        check_out("mid_rst", 1'b0, 5'd0, 32'h0);
        check("mid_rst.pend", WB_pending, 32'h0);
        step();
        check("mid_after.we", 32'(WB_reg_write), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side front end for the 32x32 register file: merges results from the ALU and the load unit into the register file's single write port.
- Provides a pending-destination scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/LSU and the register file; drives the register file's write-enable, write address and write data directly from registers.

Parameters:
- DATA_W, 32, data width of a register.
- ADDR_W, 5, register address width (32 registers).

Ports:
- WB_clk  input  1  clock; all state updates on rising edge.
- WB_rst  input  1  reset; synchronous, active-high.
- WB_alloc_valid  input  1  decode issues an instruction with a destination register.
- WB_alloc_addr  input  ADDR_W  destination register of the issued instruction.
- WB_alu_valid  input  1  ALU result available.
- WB_alu_ready  output  1  ALU result accepted this cycle.
- WB_alu_addr  input  ADDR_W  ALU destination.
- WB_alu_data  input  DATA_W  ALU result.
- WB_ld_valid  input  1  load result available.
- WB_ld_ready  output  1  load result accepted this cycle.
- WB_ld_addr  input  ADDR_W  load destination.
- WB_ld_data  input  DATA_W  load data.
- WB_reg_write  output  1  register-file write enable.
- WB_reg_addr  output  ADDR_W  register-file write address.
- WB_reg_data  output  DATA_W  register-file write data.
- WB_pending  output  32  scoreboard; bit i=1 means register i awaits a write.

Behaviour:
- Reset: WB_reg_write=0, WB_reg_addr=0, WB_reg_data=0, WB_pending=0, arbiter last-grant = LOAD (so ALU wins first conflict). WB_alu_ready/WB_ld_ready are combinational and follow arbitration of the current inputs.
- Reset mid-operation: all in-flight writes and pending bits are discarded. No write is issued in the cycle after reset.
- Handshake: a transfer occurs on a source when valid && ready at the rising edge. A source must hold valid/addr/data stable until ready.
- Arbitration: one grant per cycle; the output stage is always free, so there is no backpressure from the register file.
  - Only one source valid: that source is granted (ready=1).
  - Both valid: round-robin; the source not granted last time wins.
  - Last-grant updates only on a conflict cycle.
- Latency: a granted transfer at edge N drives WB_reg_write=1 with addr/data during cycle N..N+1. The register file commits at edge N+1. With no grant, WB_reg_write=0 next cycle and addr/data hold their previous values.
- Register 0:
  - A transfer with addr 0 completes its handshake normally but produces WB_reg_write=0.
  - Alloc with addr 0 is ignored.
  - WB_pending[0] is always 0.
- Scoreboard:
  - Set: WB_alloc_valid with addr a≠0 sets bit a at the next edge.
  - Clear: bit a clears at the edge where WB_reg_write=1 with WB_reg_addr=a, i.e. the same edge the register file commits. There is no window where the bit is 0 but the register is stale.
  - Set and clear of the same address on the same edge: set wins (a newer producer exists).
  - Alloc of an already-pending address leaves the bit 1; decode must not do this, and it is not an error here.
- Same-address writes from both sources in one cycle: ordered by the grant. The later write wins in the register file.

Decomposition:
- Shared package holds DATA_W/ADDR_W constants, the register-0 address constant, and the grant encoding (GNT_ALU=0, GNT_LD=1).
- One natural sub-module: wb_rr_arb2 (2-requester round-robin arbiter with last-grant register).
- Scoreboard and output register stay in reg_writeback.

Test Plan:
- Reset: assert WB_rst 2 cycles while both sources are valid -> WB_reg_write=0, WB_pending=0 throughout and on the first cycle after reset.
- Single ALU write: alloc 5, then alu_valid addr=5 data=0xDEADBEEF.
  - WB_pending[5]=1 after alloc.
  - WB_alu_ready=1; next cycle WB_reg_write=1, addr=5, data=0xDEADBEEF.
  - WB_pending[5] clears at the following edge.
- Conflict round-robin: alu (addr 3, 0x11) and ld (addr 4, 0x22) valid together for 2 cycles from reset.
  - Cycle 1: ALU granted. Cycle 2: load granted.
  - Outputs are addr3/0x11 then addr4/0x22.
  - WB_ld_ready=0 in cycle 1.
- Register 0: alloc 0 and alu_valid addr=0 data=0xFFFFFFFF -> WB_alu_ready=1, WB_reg_write stays 0, WB_pending stays 0.
- Set/clear collision: pending[7]=1, write to 7 on output while WB_alloc_valid addr=7 -> WB_pending[7] remains 1.
- Back-to-back stream: ld_valid held with addrs 8,9,10, no ALU traffic -> three consecutive WB_reg_write=1 cycles in order, no bubbles.
